// File: rtl/ble_aa_deframer.sv
// ---------------------------------------------------------------------------
// ble_aa_deframer
//
// BLE link-layer receive deframer. It sits behind the GFSK demodulator and
// bit slicer and takes one strobed bit at a time, LSB first.
//
// Processing steps:
//   1. Hunt for the 32-bit access address. Up to MAX_ERR bit mismatches are
//      tolerated.
//   2. After lock, de-whiten the stream.
//   3. Assemble the two PDU header bytes and the payload bytes, and hand
//      them to the packet buffer over a valid/ready handshake.
//   4. Run the trailing 24 CRC bits through the CRC-24 register and report
//      whether the residue is zero.
//
// Build option:
//   BLE_DEWHITEN_EN  When defined, the channel-seeded whitening LFSR is
//                    present and incoming bits are de-whitened.
//                    When undefined, bits are used as received and the LFSR
//                    does not exist (unwhitened test modes).
//                    CRC and framing are the same in both builds.
//
// Parameters:
//   AA        access address to match
//   MAX_ERR   maximum AA bit mismatches accepted (0..3)
//   MAX_LEN   largest payload length accepted; a larger length aborts
//   CRC_INIT  CRC register preset loaded at lock
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   bit_in      demodulated bit, qualified by bit_valid
//   bit_valid   one-cycle strobe per received bit
//   chan_idx    RF channel index 0..39, whitening seed sampled at lock
//   byte_out    de-whitened PDU byte (header first, then payload)
//   byte_valid  byte_out valid, held until accepted
//   byte_ready  consumer takes the byte when byte_valid & byte_ready
//   pkt_start   one-cycle pulse after the AA lock strobe
//   pkt_end     one-cycle pulse at packet completion or length abort
//   crc_ok      CRC residue was zero; valid from pkt_end to next pkt_start
//   len_err     one-cycle pulse with pkt_end when length > MAX_LEN
//   overflow    one-cycle pulse when a new byte replaces an unaccepted one
//   busy        high whenever the deframer is not hunting
// ---------------------------------------------------------------------------
module ble_aa_deframer #(
    parameter logic [31:0] AA       = 32'h8E89BED6,
    parameter int          MAX_ERR  = 1,
    parameter int          MAX_LEN  = 37,
    parameter logic [23:0] CRC_INIT = 24'h555555
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic [5:0] chan_idx,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       pkt_start,
    output logic       pkt_end,
    output logic       crc_ok,
    output logic       len_err,
    output logic       overflow,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_HEADER,
        ST_PAYLOAD,
        ST_CRC
    } state_t;

    localparam logic [5:0]  LP_MAX_ERR = 6'(MAX_ERR);
    localparam logic [7:0]  LP_MAX_LEN = 8'(MAX_LEN);
    localparam logic [23:0] LP_CRC_POLY = 24'h00065B;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [31:0] r_sr;
    logic [5:0]  r_aa_cnt;
    logic [23:0] r_crc;
    logic [7:0]  r_byte;
    logic [2:0]  r_bitcnt;
    logic [7:0]  r_bytecnt;
    logic [7:0]  r_len;
    logic [4:0]  r_crc_cnt;

    logic [7:0]  r_byte_out;
    logic        r_byte_valid;
    logic        r_pkt_start;
    logic        r_pkt_end;
    logic        r_crc_ok;
    logic        r_len_err;
    logic        r_overflow;
    logic        r_busy;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [31:0] w_sr_next;
    logic [5:0]  w_aa_cnt_next;
    logic [5:0]  w_aa_dist;
    logic        w_match;
    logic        w_bit_rx;
    logic        w_d;
    logic        w_fb;
    logic [23:0] w_crc_next;
    logic [7:0]  w_byte_next;
    logic        w_byte_done;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    // New bits enter at the top, so after 32 LSB-first bits sr[0] holds
    // the first bit received.
    assign w_sr_next = {bit_in, r_sr[31:1]};

    // Bits seen since entering HUNT, saturating at 32.
    assign w_aa_cnt_next = (r_aa_cnt == 6'd32) ? 6'd32 : r_aa_cnt + 6'd1;
    assign w_aa_dist     = popcount32(w_sr_next ^ AA);

    // The match is judged on the shift register as it will be after this
    // strobe, so lock and pkt_start land one cycle after the last AA bit.
    assign w_match = bit_valid && (r_state == ST_HUNT) &&
                     (w_aa_cnt_next == 6'd32) && (w_aa_dist <= LP_MAX_ERR);

    assign w_bit_rx = bit_valid && (r_state != ST_HUNT);

`ifdef BLE_DEWHITEN_EN
    // ------------------------------------------------------------------
    // Whitening LFSR (x^7 + x^4 + 1), seeded from the channel at lock
    // ------------------------------------------------------------------
    logic [6:0] r_wht;
    logic [6:0] w_wht_next;
    logic [6:0] w_wht_seed;

    assign w_wht_next = {r_wht[5], r_wht[4], r_wht[3] ^ r_wht[6],
                         r_wht[2], r_wht[1], r_wht[0], r_wht[6]};

    // The channel index is bit-reversed into w[6:1]; w[0] is forced to 1.
    assign w_wht_seed = {chan_idx[0], chan_idx[1], chan_idx[2],
                         chan_idx[3], chan_idx[4], chan_idx[5], 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wht <= '0;
        end else if (w_match) begin
            r_wht <= w_wht_seed;
        end else if (w_bit_rx) begin
            r_wht <= w_wht_next;
        end
    end

    assign w_d = bit_in ^ r_wht[6];
`else
    // Without whitening the channel index has no use.
    logic w_chan_unused;
    assign w_chan_unused = ^chan_idx;

    assign w_d = bit_in;
`endif

    // CRC-24, MSB-side feedback, fed with de-whitened bits.
    assign w_fb       = r_crc[23] ^ w_d;
    assign w_crc_next = {r_crc[22:0], 1'b0} ^ (w_fb ? LP_CRC_POLY : 24'h000000);

    // Bytes are assembled LSB first.
    assign w_byte_next = {w_d, r_byte[7:1]};
    assign w_byte_done = w_bit_rx && (r_bitcnt == 3'd7) &&
                         ((r_state == ST_HEADER) || (r_state == ST_PAYLOAD));

    // ------------------------------------------------------------------
    // Deframer FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_HUNT;
            r_sr         <= '0;
            r_aa_cnt     <= '0;
            r_crc        <= '0;
            r_byte       <= '0;
            r_bitcnt     <= '0;
            r_bytecnt    <= '0;
            r_len        <= '0;
            r_crc_cnt    <= '0;
            r_byte_out   <= '0;
            r_byte_valid <= 1'b0;
            r_pkt_start  <= 1'b0;
            r_pkt_end    <= 1'b0;
            r_crc_ok     <= 1'b0;
            r_len_err    <= 1'b0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_pkt_start <= 1'b0;
            r_pkt_end   <= 1'b0;
            r_len_err   <= 1'b0;
            r_overflow  <= 1'b0;

            if (bit_valid) begin
                r_sr <= w_sr_next;
            end

            // Output handshake. A completing byte always wins: it replaces
            // whatever is pending and keeps byte_valid high. Overflow is
            // only flagged when the pending byte was not taken this cycle.
            if (w_byte_done) begin
                r_byte_out   <= w_byte_next;
                r_byte_valid <= 1'b1;
                r_overflow   <= r_byte_valid & ~byte_ready;
            end else if (r_byte_valid && byte_ready) begin
                r_byte_valid <= 1'b0;
            end

            case (r_state)
                ST_HUNT: begin
                    if (bit_valid) begin
                        if (w_match) begin
                            r_state     <= ST_HEADER;
                            r_busy      <= 1'b1;
                            r_pkt_start <= 1'b1;
                            r_crc_ok    <= 1'b0;
                            r_crc       <= CRC_INIT;
                            r_bitcnt    <= '0;
                            r_bytecnt   <= '0;
                            r_crc_cnt   <= '0;
                            // Cleared here so the next hunt needs 32 fresh bits.
                            r_aa_cnt    <= '0;
                        end else begin
                            r_aa_cnt <= w_aa_cnt_next;
                        end
                    end
                end

                ST_HEADER: begin
                    if (bit_valid) begin
                        r_crc    <= w_crc_next;
                        r_byte   <= w_byte_next;
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            if (r_bytecnt == 8'd1) begin
                                // Second header byte is the payload length.
                                r_len     <= w_byte_next;
                                r_bytecnt <= '0;
                                if (w_byte_next > LP_MAX_LEN) begin
                                    r_state   <= ST_HUNT;
                                    r_busy    <= 1'b0;
                                    r_pkt_end <= 1'b1;
                                    r_len_err <= 1'b1;
                                    r_crc_ok  <= 1'b0;
                                end else if (w_byte_next == 8'd0) begin
                                    r_state <= ST_CRC;
                                end else begin
                                    r_state <= ST_PAYLOAD;
                                end
                            end else begin
                                r_bytecnt <= r_bytecnt + 8'd1;
                            end
                        end
                    end
                end

                ST_PAYLOAD: begin
                    if (bit_valid) begin
                        r_crc    <= w_crc_next;
                        r_byte   <= w_byte_next;
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_bytecnt <= r_bytecnt + 8'd1;
                            if ((r_bytecnt + 8'd1) == r_len) begin
                                r_state <= ST_CRC;
                            end
                        end
                    end
                end

                ST_CRC: begin
                    // The received CRC is clocked through the same register;
                    // a correct packet leaves an all-zero residue.
                    if (bit_valid) begin
                        r_crc <= w_crc_next;
                        if (r_crc_cnt == 5'd23) begin
                            r_crc_ok  <= (w_crc_next == 24'd0);
                            r_pkt_end <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= ST_HUNT;
                            r_crc_cnt <= '0;
                        end else begin
                            r_crc_cnt <= r_crc_cnt + 5'd1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_HUNT;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign byte_out   = r_byte_out;
    assign byte_valid = r_byte_valid;
    assign pkt_start  = r_pkt_start;
    assign pkt_end    = r_pkt_end;
    assign crc_ok     = r_crc_ok;
    assign len_err    = r_len_err;
    assign overflow   = r_overflow;
    assign busy       = r_busy;

endmodule

// File: tb/tb_ble_aa_deframer.sv
// ---------------------------------------------------------------------------
// tb_ble_aa_deframer
//
// Directed bench for ble_aa_deframer.
//
// How packets are generated:
//   - A small transmitter builds each packet: idle zeros, the AA (with an
//     optional error mask), the PDU, and the CRC-24 sent crc[23] first.
//   - It whitens the bits when BLE_DEWHITEN_EN is defined.
//
// How results are collected:
//   - A negedge monitor counts pulses and logs every accepted byte.
//   - Table vectors compare those results against hand-computed
//     expectations.
// ---------------------------------------------------------------------------
module tb_ble_aa_deframer;

    localparam logic [31:0] AA_WORD = 32'h8E89BED6;
`ifdef BLE_DEWHITEN_EN
    localparam logic WHITEN = 1'b1;
`else
    localparam logic WHITEN = 1'b0;
`endif

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       bit_in     = 1'b0;
    logic       bit_valid  = 1'b0;
    logic [5:0] chan_idx   = 6'd37;
    logic       byte_ready = 1'b1;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       pkt_start;
    logic       pkt_end;
    logic       crc_ok;
    logic       len_err;
    logic       overflow;
    logic       busy;

    always #5 clk = ~clk;

    ble_aa_deframer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .chan_idx   (chan_idx),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .pkt_start  (pkt_start),
        .pkt_end    (pkt_end),
        .crc_ok     (crc_ok),
        .len_err    (len_err),
        .overflow   (overflow),
        .busy       (busy)
    );

    // Monitor: running counts only; scenarios take differences.
    int         n_start  = 0;
    int         n_end    = 0;
    int         n_ovf    = 0;
    int         n_lenerr = 0;
    int         n_bytes  = 0;
    int         n_busy   = 0;
    logic       last_crc_ok = 1'b0;
    logic [7:0] blog [0:255];

    always @(negedge clk) begin
        if (pkt_start) n_start <= n_start + 1;
        if (pkt_end) begin
            n_end       <= n_end + 1;
            last_crc_ok <= crc_ok;
        end
        if (overflow) n_ovf <= n_ovf + 1;
        if (len_err) n_lenerr <= n_lenerr + 1;
        if (busy) n_busy <= n_busy + 1;
        if (byte_valid && byte_ready) begin
            blog[n_bytes[7:0]] <= byte_out;
            n_bytes            <= n_bytes + 1;
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total = n_total + 1;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass = n_pass + 1;
        end
    endtask

    // ----------------------------------------------------------------
    // Transmitter model
    // ----------------------------------------------------------------
    function automatic logic [23:0] crc_step(input logic [23:0] c, input logic d);
        return {c[22:0], 1'b0} ^ ((c[23] ^ d) ? 24'h00065B : 24'h000000);
    endfunction

    function automatic logic [6:0] lfsr_step(input logic [6:0] w);
        return {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
    endfunction

    // Called and returns at posedge+1; each bit is a one-cycle strobe
    // followed by one idle cycle.
    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk); #1;
        bit_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // Sends idle, AA ^ mask, header {hdr0,len}, payload 01,02,.. and CRC.
    // flip >= 0 inverts that payload bit on air.
    // stop_after > 0 stops after that many post-AA bits.
    task automatic send_packet(input logic [31:0] mask, input logic [7:0] hdr0,
                               input logic [7:0] len, input int flip, input int stop_after);
        logic [31:0] aa_v;
        logic [23:0] crc;
        logic [23:0] crc_tx;
        logic [6:0]  w;
        logic [7:0]  pdu [0:39];
        logic [7:0]  cur;
        logic        d;
        logic        tx;
        int          npdu;
        int          nsent;
        aa_v   = AA_WORD;
        pdu[0] = hdr0;
        pdu[1] = len;
        npdu   = (len <= 8'd37) ? int'(len) + 2 : 2;
        for (int k = 2; k < npdu; k++) pdu[k] = 8'(k - 1);
        for (int i = 0; i < 40; i++) send_bit(1'b0);
        for (int i = 0; i < 32; i++) send_bit(aa_v[i] ^ mask[i]);
        crc   = 24'h555555;
        w     = {chan_idx[0], chan_idx[1], chan_idx[2], chan_idx[3], chan_idx[4], chan_idx[5], 1'b1};
        nsent = 0;
        for (int b = 0; b < npdu; b++) begin
            cur = pdu[b];
            for (int i = 0; i < 8; i++) begin
                if (stop_after > 0 && nsent == stop_after) return;
                d   = cur[i];
                crc = crc_step(crc, d);
                tx  = d ^ (WHITEN & w[6]);
                if (b >= 2 && ((b - 2) * 8 + i) == flip) tx = ~tx;
                w = lfsr_step(w);
                send_bit(tx);
                nsent = nsent + 1;
            end
        end
        if (len <= 8'd37) begin
            crc_tx = crc;
            for (int j = 23; j >= 0; j--) begin
                tx = crc_tx[j] ^ (WHITEN & w[6]);
                w  = lfsr_step(w);
                send_bit(tx);
            end
        end
    endtask

    // ----------------------------------------------------------------
    // Vector table
    // ----------------------------------------------------------------
    typedef struct {
        logic [5:0]  chan;
        logic [31:0] aa_mask;
        logic [7:0]  len;
        int          flip;
        int          exp_start;
        int          exp_nbytes;
        logic [63:0] exp_bytes;   // byte k at [8k+7:8k]
        int          exp_end;
        logic        exp_crc_ok;
        int          exp_lenerr;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vector(input int id, input vec_t v);
        int    s_start, s_end, s_ovf, s_lenerr, s_bytes, s_busy;
        string tag;
        s_start  = n_start;
        s_end    = n_end;
        s_ovf    = n_ovf;
        s_lenerr = n_lenerr;
        s_bytes  = n_bytes;
        s_busy   = n_busy;
        chan_idx = v.chan;
        send_packet(v.aa_mask, 8'h02, v.len, v.flip, 0);
        repeat (4) @(posedge clk);
        #1;
        tag = $sformatf("v%0d", id);
        check({tag, "_pkt_start"}, 64'(n_start - s_start), 64'(v.exp_start));
        check({tag, "_nbytes"}, 64'(n_bytes - s_bytes), 64'(v.exp_nbytes));
        for (int k = 0; k < v.exp_nbytes; k++) begin
            check($sformatf("%s_byte%0d", tag, k), 64'(blog[(s_bytes + k) % 256]), 64'(v.exp_bytes[8*k +: 8]));
        end
        check({tag, "_pkt_end"}, 64'(n_end - s_end), 64'(v.exp_end));
        if (v.exp_end > 0) begin
            check({tag, "_crc_ok"}, 64'(last_crc_ok), 64'(v.exp_crc_ok));
        end
        check({tag, "_len_err"}, 64'(n_lenerr - s_lenerr), 64'(v.exp_lenerr));
        check({tag, "_overflow"}, 64'(n_ovf - s_ovf), 64'd0);
        if (v.exp_start == 0) begin
            check({tag, "_busy_never"}, 64'(n_busy - s_busy), 64'd0);
        end
    endtask

    initial begin
        int   s_end, s_ovf, s_bytes;
        vec_t v;

        vecs[0] = '{chan:6'd37, aa_mask:32'h0, len:8'd6, flip:-1, exp_start:1, exp_nbytes:8,
                    exp_bytes:64'h0605040302010602, exp_end:1, exp_crc_ok:1'b1, exp_lenerr:0};
        // Payload byte 4 (0x05), bit 2 flipped on air.
        vecs[1] = '{chan:6'd37, aa_mask:32'h0, len:8'd6, flip:34, exp_start:1, exp_nbytes:8,
                    exp_bytes:64'h0601040302010602, exp_end:1, exp_crc_ok:1'b0, exp_lenerr:0};
        vecs[2] = '{chan:6'd37, aa_mask:32'h0000_0020, len:8'd6, flip:-1, exp_start:1, exp_nbytes:8,
                    exp_bytes:64'h0605040302010602, exp_end:1, exp_crc_ok:1'b1, exp_lenerr:0};
        vecs[3] = '{chan:6'd37, aa_mask:32'h0010_0008, len:8'd6, flip:-1, exp_start:0, exp_nbytes:0,
                    exp_bytes:64'h0, exp_end:0, exp_crc_ok:1'b0, exp_lenerr:0};
        vecs[4] = '{chan:6'd37, aa_mask:32'h0, len:8'd40, flip:-1, exp_start:1, exp_nbytes:2,
                    exp_bytes:64'h2802, exp_end:1, exp_crc_ok:1'b0, exp_lenerr:1};
        vecs[5] = '{chan:6'd37, aa_mask:32'h0, len:8'd6, flip:-1, exp_start:1, exp_nbytes:8,
                    exp_bytes:64'h0605040302010602, exp_end:1, exp_crc_ok:1'b1, exp_lenerr:0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'({byte_out, byte_valid, pkt_start, pkt_end, crc_ok, len_err, overflow, busy}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_vector(i, vecs[i]);

        // Backpressure for a whole packet: the last byte stays pending.
        s_end      = n_end;
        s_ovf      = n_ovf;
        s_bytes    = n_bytes;
        byte_ready = 1'b0;
        chan_idx   = 6'd37;
        send_packet(32'h0, 8'h02, 8'd6, -1, 0);
        repeat (4) @(posedge clk);
        #1;
        check("bp_overflow", 64'(n_ovf - s_ovf), 64'd7);
        check("bp_no_accept", 64'(n_bytes - s_bytes), 64'd0);
        check("bp_pkt_end", 64'(n_end - s_end), 64'd1);
        check("bp_crc_ok", 64'(last_crc_ok), 64'd1);
        check("bp_held", 64'({byte_valid, byte_out}), 64'h106);
        byte_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("bp_drain_count", 64'(n_bytes - s_bytes), 64'd1);
        check("bp_drain_byte", 64'(blog[s_bytes % 256]), 64'h06);
        check("bp_drain_valid", 64'(byte_valid), 64'd0);

        // Reset in the middle of the payload: no pkt_end.
        s_end    = n_end;
        chan_idx = 6'd37;
        send_packet(32'h0, 8'h02, 8'd6, -1, 40);
        check("rst_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_outputs", 64'({byte_out, byte_valid, pkt_start, pkt_end, crc_ok, len_err, overflow, busy}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs_held", 64'({byte_out, byte_valid, pkt_start, pkt_end, crc_ok, len_err, overflow, busy}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_no_pkt_end", 64'(n_end - s_end), 64'd0);

        // Clean packet on channel 12 after the reset.
        v      = vecs[0];
        v.chan = 6'd12;
        run_vector(6, v);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
